// File: rtl/conv_frame_sched.sv
// Frame scheduler: walks every stride-1 valid-padding conv output position,
// pulsing clr/start to the MAC, waiting for mac_done and handing each result
// downstream on a valid/ready handshake.
// Ports: clk, rst_n (async low), en (run level), abort (sync), clr/start and
// win_addr to the MAC, mac_done/mac_acc from the MAC, res_valid/res_ready/
// res_data/res_row/res_col downstream, busy, frame_done pulse, err (sticky).
// Optional: define CONV_FRAME_SCHED_TIMEOUT_EN to add the mac_done timeout.
module conv_frame_sched #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int ACC_W   = 20,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              abort,
    output logic              clr,
    output logic              start,
    output logic [ADDR_W-1:0] win_addr,
    input  logic              mac_done,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [ADDR_W-1:0] res_row,
    output logic [ADDR_W-1:0] res_col,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_START, S_WAIT, S_OUT, S_DONE, S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] win_addr_q, win_addr_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_row_q, res_row_d;
    logic [ADDR_W-1:0] res_col_q, res_col_d;
    logic              err_q, err_d;

`ifdef CONV_FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        res_data_d = res_data_q;
        res_row_d  = res_row_q;
        res_col_d  = res_col_q;
        err_d      = err_q;
        unique case (state_q)
            S_IDLE:  if (en) state_d = S_CLR;
            S_CLR:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mac_done) begin
                    res_data_d = mac_acc;
                    res_row_d  = row_q;
                    res_col_d  = col_q;
                    state_d    = S_OUT;
                end
`ifdef CONV_FRAME_SCHED_TIMEOUT_EN
                else if (tmo_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_OUT: begin
                if (res_ready) begin
                    if (row_q == LAST_R && col_q == LAST_C) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLR;
                        if (col_q == LAST_C) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_HOLD;
            S_HOLD:  if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
        // position counters only ever live at zero while idle
        if (state_d == S_IDLE) begin
            row_d = '0;
            col_d = '0;
        end
        win_addr_d = row_d * IMG_W_A + col_d;
    end

`ifdef CONV_FRAME_SCHED_TIMEOUT_EN
    // nonzero only while in WAIT, so it restarts on every WAIT entry
    assign tmo_d = (state_q == S_WAIT) ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            win_addr_q <= '0;
            res_data_q <= '0;
            res_row_q  <= '0;
            res_col_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            win_addr_q <= win_addr_d;
            res_data_q <= res_data_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
            err_q      <= err_d;
        end
    end

    assign clr        = (state_q == S_CLR);
    assign start      = (state_q == S_START);
    assign res_valid  = (state_q == S_OUT);
    assign frame_done = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign win_addr   = win_addr_q;
    assign res_data   = res_data_q;
    assign res_row    = res_row_q;
    assign res_col    = res_col_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_frame_sched.sv
// Testbench for conv_frame_sched: 4x4 image / 3x3 kernel instance plus a
// degenerate 3x3 / 3x3 instance, MAC emulated with random latency and data.
module tb_conv_frame_sched;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int KK = 3;
    localparam int OW = W - KK + 1;
    localparam int OH = H - KK + 1;

    logic        clk, rst_n, en, abort;
    logic        clr, start, mac_done, res_valid, res_ready;
    logic        busy, frame_done, err;
    logic [15:0] win_addr, res_row, res_col;
    logic [19:0] mac_acc, res_data;

    logic        en1, mac_done1, res_ready1;
    logic        d1_clr, d1_start, d1_valid, d1_busy, d1_fd, d1_err;
    logic [15:0] d1_addr, d1_row, d1_col;
    logic [19:0] mac_acc1, d1_data;

    int checks = 0;
    int errors = 0;
    logic exp_err = 1'b0;

    conv_frame_sched #(
        .IMG_W(W), .IMG_H(H), .K(KK), .ACC_W(20), .ADDR_W(16), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .abort(abort),
        .clr(clr), .start(start), .win_addr(win_addr),
        .mac_done(mac_done), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .res_col(res_col),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    conv_frame_sched #(
        .IMG_W(3), .IMG_H(3), .K(3), .ACC_W(20), .ADDR_W(16), .TIMEOUT(10)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .abort(1'b0),
        .clr(d1_clr), .start(d1_start), .win_addr(d1_addr),
        .mac_done(mac_done1), .mac_acc(mac_acc1),
        .res_valid(d1_valid), .res_ready(res_ready1),
        .res_data(d1_data), .res_row(d1_row), .res_col(d1_col),
        .busy(d1_busy), .frame_done(d1_fd), .err(d1_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // entered in the CLR cycle of window (r,c); leaves after the handshake
    task automatic window(input int r, input int c, input int dly,
                          input int stall, input logic [19:0] acc);
        int a;
        a = r * W + c;
        chk("clr", clr, 1);
        chk("clr_start", start, 0);
        chk("clr_addr", win_addr, a);
        chk("clr_busy", busy, 1);
        mac_done = 1'b1;
        mac_acc  = 20'($urandom);
        step;
        chk("start", start, 1);
        chk("start_clr", clr, 0);
        chk("start_addr", win_addr, a);
        mac_done = 1'b0;
        step;
        chk("wait_valid", res_valid, 0);
        chk("wait_addr", win_addr, a);
        repeat (dly) begin
            step;
            chk("wait_hold", {res_valid, start, clr}, 0);
        end
        mac_done = 1'b1;
        mac_acc  = acc;
        step;
        mac_done = 1'b0;
        mac_acc  = 20'($urandom);
        chk("out_valid", res_valid, 1);
        chk("out_data", res_data, acc);
        chk("out_row", res_row, r);
        chk("out_col", res_col, c);
        repeat (stall) begin
            step;
            chk("stall_valid", res_valid, 1);
            chk("stall_data", res_data, acc);
            chk("stall_pos", {res_row, res_col}, {r[15:0], c[15:0]});
            chk("stall_nomac", {clr, start}, 0);
        end
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
    endtask

    // full frame from IDLE; result number stall_idx is backpressured
    task automatic run_frame(input int stall_idx, input int stall_len,
                             input bit use_abc);
        int n;
        logic [19:0] acc;
        n  = 0;
        en = 1'b1;
        step;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                acc = (use_abc && n == 0) ? 20'h00ABC : 20'($urandom);
                window(r, c, $urandom_range(0, 4),
                       (n == stall_idx) ? stall_len : 0, acc);
                n++;
            end
        end
        chk("frame_done", frame_done, 1);
        chk("done_valid", res_valid, 0);
        chk("done_err", err, exp_err);
        step;
        chk("hold_fd", frame_done, 0);
        chk("hold_busy", busy, 1);
        chk("hold_clr", clr, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        {en, abort, mac_done, res_ready} = '0;
        {en1, mac_done1, res_ready1} = '0;
        mac_acc  = '0;
        mac_acc1 = '0;
        #2 rst_n = 1'b0;
        step;
        chk("rst_ctl", {clr, start, res_valid, busy, frame_done, err}, 0);
        chk("rst_data", {res_data, res_row, res_col, win_addr}, 0);
        rst_n = 1'b1;
        step;
        chk("idle_busy", busy, 0);

        run_frame(-1, 0, 1'b0);

        repeat (3) begin
            step;
            chk("hold_noretrig", {clr, start, frame_done}, 0);
            chk("hold_busy2", busy, 1);
        end
        en = 1'b0;
        step;
        chk("back_idle", busy, 0);

        run_frame(1, 5, 1'b1);
        en = 1'b0;
        step;

        en = 1'b1;
        step;
        window(0, 0, 1, 0, 20'($urandom));
        window(0, 1, 2, 0, 20'($urandom));
        step;
        step;
        chk("pre_abort_wait", {busy, clr, start}, 3'b100);
        abort = 1'b1;
        en    = 1'b0;
        step;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", res_valid, 0);
        repeat (3) begin
            chk("abort_nofd", frame_done, 0);
            step;
        end
        run_frame(-1, 0, 1'b0);
        en = 1'b0;
        step;

        en = 1'b1;
        step;
        window(0, 0, 0, 0, 20'($urandom));
        chk("pre_rst_addr", win_addr, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {clr, start, busy, res_valid}, 0);
        chk("mid_rst_addr", win_addr, 0);
        chk("mid_rst_res", {res_data, res_row, res_col}, 0);
        en = 1'b0;
        step;
        rst_n = 1'b1;
        step;

`ifdef CONV_FRAME_SCHED_TIMEOUT_EN
        en = 1'b1;
        step;
        step;
        step;
        repeat (9) begin
            chk("tmo_wait", {busy, err}, 2'b10);
            step;
        end
        chk("tmo_last", {busy, err}, 2'b10);
        en = 1'b0;
        step;
        chk("tmo_err", err, 1);
        chk("tmo_idle", {busy, frame_done}, 0);
        exp_err = 1'b1;
        run_frame(-1, 0, 1'b0);
        en = 1'b0;
        step;
        rst_n = 1'b0;
        #1;
        chk("tmo_rst", err, 0);
        exp_err = 1'b0;
        step;
        rst_n = 1'b1;
        step;
`endif
        chk("err_final", err, exp_err);

        en1 = 1'b1;
        step;
        chk("d1_clr", {d1_clr, d1_addr}, {1'b1, 16'd0});
        step;
        chk("d1_start", d1_start, 1);
        step;
        mac_done1 = 1'b1;
        mac_acc1  = 20'($urandom);
        step;
        mac_done1 = 1'b0;
        chk("d1_valid", d1_valid, 1);
        chk("d1_data", d1_data, mac_acc1);
        chk("d1_pos", {d1_row, d1_col}, 0);
        res_ready1 = 1'b1;
        step;
        res_ready1 = 1'b0;
        chk("d1_fd", {d1_fd, d1_valid, d1_clr}, 3'b100);
        en1 = 1'b0;
        step;
        step;
        chk("d1_idle", {d1_busy, d1_err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
